coordinate_reader: RTL

Reads back the (x, y) coordinate pairs that the coordinate collector wrote into the coordinate memory and streams them, in address order, to the pathfinding core over a valid/ready handshake. It is the read-side counterpart of the collector: the collector owns the write port, and this block owns the read port of the same memory. It sits between that memory and the pathfinding datapath.

---
 rtl/coordinate_reader_if.sv | 26 ++
 rtl/coordinate_reader.sv | 110 +++++++++++
 2 files changed

// File: rtl/coordinate_reader_if.sv
// Memory read port and coordinate stream shared by the coordinate reader and its neighbours.
// master = the reader; slave = the memory model / pathfinding side.
interface coordinate_reader_if #(
  parameter int ADDR_W  = 8,
  parameter int COORD_W = 8
);
  logic [ADDR_W-1:0]    mem_addr;
  logic                 mem_rden;
  logic [2*COORD_W-1:0] mem_rdata;
  logic                 coord_valid;
  logic                 coord_ready;
  logic [COORD_W-1:0]   x_out;
  logic [COORD_W-1:0]   y_out;
  logic [ADDR_W-1:0]    coord_index;
  logic                 last;

  modport master (
    output mem_addr, mem_rden, coord_valid, x_out, y_out, coord_index, last,
    input  mem_rdata, coord_ready
  );

  modport slave (
    input  mem_addr, mem_rden, coord_valid, x_out, y_out, coord_index, last,
    output mem_rdata, coord_ready
  );
endinterface

// File: rtl/coordinate_reader.sv
// Streams the stored (x, y) pairs from the coordinate memory, in address order,
// to the pathfinding core over a valid/ready handshake.
module coordinate_reader #(
  parameter int ADDR_W  = 8,
  parameter int COORD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] coord_count,
  coordinate_reader_if.master bus,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FETCH   = 3'd1;
  localparam logic [2:0] CAPTURE = 3'd2;
  localparam logic [2:0] PRESENT = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]        state_r;
  logic [2:0]        state_s;
  logic [ADDR_W-1:0] cnt_r;
  logic [ADDR_W-1:0] cnt_s;
  logic [ADDR_W-1:0] idx_r;
  logic [ADDR_W-1:0] idx_s;
  logic              xfer_s;

  assign xfer_s = bus.coord_valid && bus.coord_ready;

  // Next-state, latched count and pair index.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          cnt_s   = coord_count;
          idx_s   = {ADDR_W{1'b0}};
          state_s = (coord_count == {ADDR_W{1'b0}}) ? DONE : FETCH;
        end else begin
          state_s = state_r;
        end
      end
      FETCH: begin
        state_s = CAPTURE;
      end
      CAPTURE: begin
        state_s = PRESENT;
      end
      PRESENT: begin
        if (xfer_s) begin
          if (bus.last) begin
            state_s = DONE;
          end else begin
            idx_s   = idx_r + ADDR_W'(1);
            state_s = FETCH;
          end
        end else begin
          state_s = PRESENT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State registers and registered outputs, all derived from the next state so
  // each output is valid in the same cycle as the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= IDLE;
      cnt_r           <= {ADDR_W{1'b0}};
      idx_r           <= {ADDR_W{1'b0}};
      bus.mem_addr    <= {ADDR_W{1'b0}};
      bus.mem_rden    <= 1'b0;
      bus.coord_valid <= 1'b0;
      bus.x_out       <= {COORD_W{1'b0}};
      bus.y_out       <= {COORD_W{1'b0}};
      bus.coord_index <= {ADDR_W{1'b0}};
      bus.last        <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      state_r         <= state_s;
      cnt_r           <= cnt_s;
      idx_r           <= idx_s;
      bus.mem_addr    <= idx_s;
      bus.mem_rden    <= (state_s == FETCH);
      bus.coord_valid <= (state_s == PRESENT);
      busy            <= (state_s == FETCH) || (state_s == CAPTURE) || (state_s == PRESENT);
      done            <= (state_s == DONE);
      // Read data is valid in CAPTURE only; the presented pair then holds until accepted.
      if (state_r == CAPTURE) begin
        bus.x_out       <= bus.mem_rdata[2*COORD_W-1:COORD_W];
        bus.y_out       <= bus.mem_rdata[COORD_W-1:0];
        bus.coord_index <= idx_r;
        bus.last        <= (idx_r == (cnt_r - ADDR_W'(1)));
      end else if (state_s != PRESENT) begin
        bus.last        <= 1'b0;
      end else begin
        bus.last        <= bus.last;
      end
    end
  end

endmodule
